alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a combinational 32-bit ALU through single- and multi-pass ops
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/ready/op/a/b/tag    request channel (accepted only in IDLE)
//   alu_a/alu_b/alu_ctrl          operands and alucontrol to the ALU
//   alu_result                    combinational ALU result
//   rsp_valid/ready/result/zero/err/tag  response channel, held until accepted
module alu_op_sequencer #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [31:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t           r_state;
   logic [3:0]       r_op;
   logic [31:0]      r_a, r_b, r_t1, r_t2, r_result;
   logic [TAG_W-1:0] r_tag;
   logic [1:0]       r_pass;
   logic             r_req_ready, r_rsp_valid, r_zero, r_err;
   logic             w_illegal, w_last;
   assign w_illegal  = r_op > 4'd9;
   // OR takes three passes, SGE two, everything else one
   assign w_last     = r_pass == (r_op == 4'd5 ? 2'd2 : r_op == 4'd6 ? 2'd1 : 2'd0);
   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_err    = r_err;
   assign rsp_tag    = r_tag;
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = 3'b000;
      if (r_state == EXEC)
         case (r_op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
               alu_a    = r_a;
               alu_b    = r_b;
               alu_ctrl = r_op == 4'd4 ? 3'b101 : r_op[2:0];
            end
            // OR = (a^b) ^ (a&b)
            4'd5: begin
               alu_a    = r_pass == 2'd2 ? r_t1 : r_a;
               alu_b    = r_pass == 2'd2 ? r_t2 : r_b;
               alu_ctrl = r_pass == 2'd1 ? 3'b010 : 3'b011;
            end
            // SGE = !(a<b)
            4'd6: begin
               alu_a    = r_pass == 2'd1 ? r_t1 : r_a;
               alu_b    = r_pass == 2'd1 ? 32'd1 : r_b;
               alu_ctrl = r_pass == 2'd1 ? 3'b011 : 3'b101;
            end
            4'd7: begin
               alu_b    = r_b;
               alu_ctrl = 3'b001;
            end
            4'd8: begin
               alu_a    = r_a;
               alu_b    = 32'hFFFF_FFFF;
               alu_ctrl = 3'b011;
            end
            4'd9: begin
               alu_a    = r_b;
               alu_b    = r_a;
               alu_ctrl = 3'b101;
            end
            default: alu_ctrl = 3'b100;
         endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_t1        <= '0;
         r_t2        <= '0;
         r_result    <= '0;
         r_tag       <= '0;
         r_pass      <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_err       <= 1'b0;
      end else
         case (r_state)
            IDLE:
               if (req_valid) begin
                  r_op        <= req_op;
                  r_a         <= req_a;
                  r_b         <= req_b;
                  r_tag       <= req_tag;
                  r_pass      <= '0;
                  r_req_ready <= 1'b0;
                  r_state     <= EXEC;
               end
            EXEC:
               if (w_last) begin
                  r_result    <= w_illegal ? '0 : alu_result;
                  r_zero      <= w_illegal | ~|alu_result;
                  r_err       <= w_illegal;
                  r_rsp_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  if (r_pass == 2'd0) r_t1 <= alu_result;
                  else r_t2 <= alu_result;
                  r_pass <= r_pass + 2'd1;
               end
            DONE:
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with an ALU stand-in and an opcode-level reference model
module tb_alu_op_sequencer;
   logic        clk = 0, reset = 1;
   logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_zero, rsp_err;
   logic [3:0]  req_op = 0, req_tag = 0, rsp_tag;
   logic [31:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_result, rsp_result;
   logic [2:0]  alu_ctrl;
   int          checks = 0, errors = 0, mode = 0;
   typedef struct {logic [31:0] r; logic z, e; logic [3:0] t;} exp_t;
   exp_t q[$];
   alu_op_sequencer #(.TAG_W(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
   );
   always #5 clk = ~clk;
   always_comb
      case (alu_ctrl)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = alu_a & alu_b;
         3'b011:  alu_result = alu_a ^ alu_b;
         3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a ^ b;
         4'd4: return {31'd0, $signed(a) < $signed(b)};
         4'd5: return a | b;
         4'd6: return {31'd0, $signed(a) >= $signed(b)};
         4'd7: return 32'd0 - b;
         4'd8: return ~a;
         4'd9: return {31'd0, $signed(a) > $signed(b)};
         default: return 32'd0;
      endcase
   endfunction
   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      rsp_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
   end
   always @(negedge clk)
      if (!reset && rsp_valid && rsp_ready) begin
         if (q.size() == 0) chk("unexpected_rsp", rsp_result, 32'hx);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_result", rsp_result, e.r);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
            chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.t});
         end
      end
   task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic [3:0] tag, input bit push);
      int w = 0;
      while (!req_ready && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      else begin
         req_valid = 1;
         req_op = op;
         req_a = a;
         req_b = b;
         req_tag = tag;
         @(posedge clk);
         #1;
         req_valid = 0;
         if (push) begin
            exp_t e;
            e.r = model(op, a, b);
            e.e = op > 4'd9;
            e.z = e.r == 0;
            e.t = tag;
            q.push_back(e);
         end
      end
   endtask
   task automatic dir(input logic [3:0] op, input logic [31:0] a, b, input logic [3:0] tag,
                      input int n, input logic [8:0] ctrls);
      int cnt = 0;
      issue(op, a, b, tag, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
         if (k < n) chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ctrls[3*k+:3]});
         cnt++;
      end
      chk("latency", cnt, n);
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      @(negedge clk);
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_result", rsp_result, 32'd0);
      chk("reset_rsp_flags", {29'd0, rsp_zero, rsp_err, 1'b0}, 32'd0);
      chk("reset_rsp_tag", {28'd0, rsp_tag}, 32'd0);
      chk("reset_alu", alu_a | alu_b | {29'd0, alu_ctrl}, 32'd0);
      @(posedge clk);
      #1;
      dir(4'd0, 32'hFFFF_FFFF, 32'd1, 4'h1, 1, 9'b000_000_000);
      dir(4'd5, 32'h0F0F_0000, 32'h00FF_00F0, 4'h2, 3, 9'b011_010_011);
      dir(4'd4, 32'h8000_0000, 32'd1, 4'h3, 1, 9'b000_000_101);
      dir(4'd6, 32'd5, 32'hFFFF_FFFD, 4'h4, 2, 9'b000_011_101);
      dir(4'd9, 32'd2, 32'd7, 4'h5, 1, 9'b000_000_101);
      dir(4'hC, 32'h1234, 32'h5678, 4'hA, 1, 9'b000_000_100);
      dir(4'd8, 32'h0000_FFFF, 32'd0, 4'h6, 1, 9'b000_000_011);
      @(negedge clk);
      mode = 2;
      issue(4'd7, 32'd9, 32'd1, 4'h7, 1);
      for (int w = 0; w < 20 && !rsp_valid; w++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_result", rsp_result, 32'hFFFF_FFFF);
         chk("bp_rsp_tag", {28'd0, rsp_tag}, 32'h7);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      mode = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      issue(4'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'h8, 0);
      @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      @(negedge clk);
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("abort_rsp_valid_2", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      dir(4'd0, 32'd3, 32'd4, 4'h9, 1, 9'b000_000_000);
      @(negedge clk);
      mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, b;
         a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
         b = $urandom_range(0, 3) == 0 ? a : $urandom;
         issue(4'($urandom_range(0, 15)), a, b, 4'($urandom), 1);
      end
      for (int w = 0; w < 2000 && q.size() != 0; w++) @(negedge clk);
      if (q.size() != 0) chk("drain", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
